// File: rtl/val_ready_pkg.sv
// Shared definitions for the valid/ready pipeline stages: skid buffer state
// encoding and the default data width.
package val_ready_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_e;

endpackage : val_ready_pkg

// File: rtl/val_ready_skid_buffer.sv
// Two-entry skid buffer: registered valid/ready slice with full throughput.
// Optional upstream stall counter enabled by VAL_READY_SKID_STALL_CNT_EN.
module val_ready_skid_buffer
  import val_ready_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] data_in,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] data_out
`ifdef VAL_READY_SKID_STALL_CNT_EN
  ,
  output logic [CW-1:0] stall_cnt_o
`endif
);

  skid_state_e   state_q, state_d;
  logic [DW-1:0] main_q, skid_q;
  logic          beat_in, beat_out;
  logic          load_main, load_skid, main_from_skid;

  // Handshake outputs decode from the state flops only, keeping ready_o and
  // valid_o free of any combinational path from valid_i/ready_i.
  assign valid_o  = (state_q != EMPTY);
  assign ready_o  = (state_q != FULL);
  assign data_out = main_q;

  assign beat_in  = valid_i && ready_o;
  assign beat_out = valid_o && ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first; a path that leaves
    // one unassigned would infer a latch.
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (beat_in) begin
          state_d   = BUSY;
          load_main = 1'b1;
        end
      end
      BUSY: begin
        if (beat_in && beat_out) begin
          load_main = 1'b1;
        end else if (beat_in) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (beat_out) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (beat_out) begin
          state_d        = BUSY;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: the data registers are reset (not just the state) so data_out
    // reads a defined zero after reset instead of a stale beat.
    if (rst_i) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : data_in;
      if (load_skid) skid_q <= data_in;
    end
  end

`ifdef VAL_READY_SKID_STALL_CNT_EN
  logic [CW-1:0] stall_cnt_q;

  // Counts upstream cycles refused by a full buffer; saturates, never wraps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (valid_i && !ready_o && (stall_cnt_q != {CW{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_cw;
  assign unused_cw = (CW > 0);
`endif

endmodule : val_ready_skid_buffer

// File: tb/tb_val_ready_skid_buffer.sv
// Directed, table-driven bench for val_ready_skid_buffer, with hand-written
// sequences for asynchronous reset and (when enabled) the stall counter.
module tb_val_ready_skid_buffer;

  localparam int DW = 32;
`ifdef VAL_READY_SKID_STALL_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [DW-1:0] data_in = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [DW-1:0] data_out;
`ifdef VAL_READY_SKID_STALL_CNT_EN
  logic [CW-1:0] stall_cnt_o;
`endif

  val_ready_skid_buffer #(.DW(DW), .CW(CW)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_in  (data_in),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_out (data_out)
`ifdef VAL_READY_SKID_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs applied for one edge, and the outputs expected just after it.
  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          r;
    logic          exp_valid;
    logic          exp_ready;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [DW-1:0] d, input logic r,
                     input logic ev, input logic er, input logic [DW-1:0] ed);
    vecs.push_back('{v: v, d: d, r: r, exp_valid: ev, exp_ready: er, exp_data: ed});
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    valid_i = v;
    data_in = d;
    ready_i = r;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Idle after reset
    for (int i = 0; i < 5; i++) add(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
    // Streaming 0x10..0x17, then the last beat drains; data_out holds
    for (int i = 0; i < 8; i++)
      add(1'b1, 32'h10 + i, 1'b1, 1'b1, 1'b1, 32'h10 + i);
    add(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h17);
    // Backpressure: A1 main, A2 skid, A3 refused; then release in order
    add(1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 32'hA1);
    add(1'b1, 32'hA2, 1'b0, 1'b1, 1'b0, 32'hA1);
    add(1'b1, 32'hA3, 1'b0, 1'b1, 1'b0, 32'hA1);
    add(1'b1, 32'hA3, 1'b0, 1'b1, 1'b0, 32'hA1);
    add(1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 32'hA2);
    add(1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 32'hA3);
    add(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'hA3);
    // Drain a single beat
    add(1'b1, 32'h55, 1'b0, 1'b1, 1'b1, 32'h55);
    add(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h55);
    add(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h55);
    // valid_i drops while stalled; held beat stays put, idle data ignored
    add(1'b1, 32'h66, 1'b0, 1'b1, 1'b1, 32'h66);
    add(1'b0, 32'h77, 1'b0, 1'b1, 1'b1, 32'h66);
    add(1'b0, 32'h88, 1'b1, 1'b0, 1'b1, 32'h66);

    // Reset state, checked during reset and after an off-edge release
    #3;
    check("rst_valid", valid_o, 1'b0);
    check("rst_ready", ready_o, 1'b1);
    check("rst_data", data_out, 32'h0);
`ifdef VAL_READY_SKID_STALL_CNT_EN
    check("rst_stall", stall_cnt_o, 0);
`endif
    #9 rst_i = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d, vecs[i].r);
      check($sformatf("vec%0d_valid", i), valid_o, vecs[i].exp_valid);
      check($sformatf("vec%0d_ready", i), ready_o, vecs[i].exp_ready);
      check($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
    end

    // Mid-operation asynchronous reset while FULL
    step(1'b1, 32'hB0, 1'b0);
    step(1'b1, 32'hB1, 1'b0);
    check("full_ready", ready_o, 1'b0);
    check("full_data", data_out, 32'hB0);
    #3 rst_i = 1'b1;
    #1;
    check("async_rst_valid", valid_o, 1'b0);
    check("async_rst_ready", ready_o, 1'b1);
    check("async_rst_data", data_out, 32'h0);
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b1);
      check($sformatf("post_rst%0d_valid", i), valid_o, 1'b0);
      check($sformatf("post_rst%0d_data", i), data_out, 32'h0);
    end
    // First beat after reset comes from main, then the skid beat (not zero)
    step(1'b1, 32'hC0, 1'b0);
    step(1'b1, 32'hC1, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    check("post_rst_main", data_out, 32'hC1);
    check("post_rst_main_valid", valid_o, 1'b1);

`ifdef VAL_READY_SKID_STALL_CNT_EN
    // Saturating stall counter with CW=2
    rst_i = 1'b1;
    #2 rst_i = 1'b0;
    step(1'b1, 32'hD0, 1'b0);
    step(1'b1, 32'hD1, 1'b0);
    check("stall_pre", stall_cnt_o, 0);
    begin
      int exp_cnt [6] = '{1, 2, 3, 3, 3, 3};
      for (int i = 0; i < 6; i++) begin
        step(1'b1, 32'hD2, 1'b0);
        check($sformatf("stall%0d", i), stall_cnt_o, exp_cnt[i]);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule : tb_val_ready_skid_buffer
